// File: rtl/axi_rd_arbiter_rr.sv
// axi_rd_arbiter_rr
// Round-robin arbiter that shares one AXI4 read port among NCH read masters.
// One transaction is in flight at a time. The granted channel's AR beat is
// forwarded upstream, and the R burst is routed back to that channel only.
// Each R burst is checked against its ARLEN. A mismatch raises a sticky error.
//
// Ports:
//   I_clk, I_rst          clock (rising edge), async active-high reset
//   I_axi_r*/O_axi_rready upstream R channel
//   O_axi_ar*/I_axi_arready upstream AR channel
//   I_ch_ar*/O_ch_arready per-channel AR requests, channel k at slice k
//   O_ch_r*/I_ch_rready   per-channel R responses, channel k at slice k
//   O_grant               index of the channel currently owning the port
//   O_busy                high whenever the arbiter is not idle
//   I_err_clr/O_burst_err sticky RLAST/length mismatch flag and its clear
module axi_rd_arbiter_rr #(
  parameter  int NCH = 2,
  parameter  int AW  = 32,
  parameter  int DW  = 64,
  localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [DW-1:0]     I_axi_rdata,
  input  logic              I_axi_rvalid,
  input  logic              I_axi_rlast,
  output logic              O_axi_rready,
  output logic [AW-1:0]     O_axi_araddr,
  input  logic              I_axi_arready,
  output logic              O_axi_arvalid,
  output logic [7:0]        O_axi_arlen,
  output logic [2:0]        O_axi_arsize,
  output logic [1:0]        O_axi_arburst,
  input  logic [NCH*AW-1:0] I_ch_araddr,
  input  logic [NCH-1:0]    I_ch_arvalid,
  input  logic [NCH*8-1:0]  I_ch_arlen,
  input  logic [NCH*3-1:0]  I_ch_arsize,
  input  logic [NCH*2-1:0]  I_ch_arburst,
  output logic [NCH-1:0]    O_ch_arready,
  output logic [NCH*DW-1:0] O_ch_rdata,
  output logic [NCH-1:0]    O_ch_rvalid,
  output logic [NCH-1:0]    O_ch_rlast,
  input  logic [NCH-1:0]    I_ch_rready,
  output logic [GW-1:0]     O_grant,
  output logic              O_busy,
  input  logic              I_err_clr,
  output logic              O_burst_err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_RD} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] rr_ptr, rr_nxt;
  logic [7:0]    beat_cnt, beat_nxt;
  logic          burst_err, err_set;

  logic [GW-1:0] pick;
  logic          found;
  logic [GW-1:0] grant_inc;

  logic          g_arvalid, g_rready;
  logic [AW-1:0] g_araddr;
  logic [7:0]    g_arlen;
  logic [2:0]    g_arsize;
  logic [1:0]    g_arburst;

  // Select the granted channel's request fields. A compare loop is used
  // instead of a computed slice, so a grant index >= NCH can never
  // address past the bus when NCH is not a power of two.
  always_comb begin
    g_arvalid = 1'b0;
    g_rready  = 1'b0;
    g_araddr  = '0;
    g_arlen   = '0;
    g_arsize  = '0;
    g_arburst = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == GW'(k)) begin
        g_arvalid = I_ch_arvalid[k];
        g_rready  = I_ch_rready[k];
        g_araddr  = I_ch_araddr[k*AW +: AW];
        g_arlen   = I_ch_arlen[k*8 +: 8];
        g_arsize  = I_ch_arsize[k*3 +: 3];
        g_arburst = I_ch_arburst[k*2 +: 2];
      end
    end
  end

  // Scan starting at rr_ptr. The first requester found wins. rr_ptr
  // points one past the last served channel, so that channel is checked last.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < NCH; i++) begin
      if (!found && I_ch_arvalid[(int'(rr_ptr) + i) % NCH]) begin
        found = 1'b1;
        pick  = GW'((int'(rr_ptr) + i) % NCH);
      end
    end
  end

  assign grant_inc = (grant == GW'(NCH - 1)) ? '0 : grant + GW'(1);

  // Next-state logic and datapath routing. Routing is active only in AR
  // (address) and RD (data). In IDLE every output stays quiet.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_nxt        = rr_ptr;
    beat_nxt      = beat_cnt;
    err_set       = 1'b0;
    O_axi_arvalid = 1'b0;
    O_axi_araddr  = '0;
    O_axi_arlen   = '0;
    O_axi_arsize  = '0;
    O_axi_arburst = '0;
    O_axi_rready  = 1'b0;
    O_ch_arready  = '0;
    O_ch_rdata    = '0;
    O_ch_rvalid   = '0;
    O_ch_rlast    = '0;

    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = S_AR;
        end
      end

      S_AR: begin
        O_axi_arvalid = g_arvalid;
        O_axi_araddr  = g_araddr;
        O_axi_arlen   = g_arlen;
        O_axi_arsize  = g_arsize;
        O_axi_arburst = g_arburst;
        for (int k = 0; k < NCH; k++)
          O_ch_arready[k] = (grant == GW'(k)) & I_axi_arready;
        // The master withdrew its request before the handshake. Drop the
        // grant, and leave rr_ptr alone because nothing was served.
        if (!g_arvalid) begin
          state_nxt = S_IDLE;
        end else if (I_axi_arready) begin
          beat_nxt  = g_arlen;
          rr_nxt    = grant_inc;
          state_nxt = S_RD;
        end
      end

      S_RD: begin
        O_axi_rready = g_rready;
        for (int k = 0; k < NCH; k++) begin
          if (grant == GW'(k)) begin
            O_ch_rdata[k*DW +: DW] = I_axi_rdata;
            O_ch_rvalid[k]         = I_axi_rvalid;
            O_ch_rlast[k]          = I_axi_rlast;
          end
        end
        // beat_cnt holds the beats still owed after the current one. It must be
        // zero exactly when RLAST arrives. An extra beat saturates at zero.
        if (I_axi_rvalid && g_rready) begin
          if (I_axi_rlast) begin
            state_nxt = S_IDLE;
            err_set   = (beat_cnt != 8'd0);
          end else if (beat_cnt == 8'd0) begin
            err_set = 1'b1;
          end else begin
            beat_nxt = beat_cnt - 8'd1;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State registers. A new error takes priority over a clear in the same cycle.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
      if (err_set)
        burst_err <= 1'b1;
      else if (I_err_clr)
        burst_err <= 1'b0;
    end
  end

  assign O_grant     = grant;
  assign O_busy      = (state != S_IDLE);
  assign O_burst_err = burst_err;

endmodule

// File: tb/tb_axi_rd_arbiter_rr.sv
// Directed testbench for axi_rd_arbiter_rr, built with four channels.
// Each transaction is driven by hand. Every expected value is written
// out from the round-robin order and the burst rules.
module tb_axi_rd_arbiter_rr;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int GW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     I_axi_rdata;
  logic              I_axi_rvalid;
  logic              I_axi_rlast;
  logic              O_axi_rready;
  logic [AW-1:0]     O_axi_araddr;
  logic              I_axi_arready;
  logic              O_axi_arvalid;
  logic [7:0]        O_axi_arlen;
  logic [2:0]        O_axi_arsize;
  logic [1:0]        O_axi_arburst;
  logic [NCH*AW-1:0] I_ch_araddr;
  logic [NCH-1:0]    I_ch_arvalid;
  logic [NCH*8-1:0]  I_ch_arlen;
  logic [NCH*3-1:0]  I_ch_arsize;
  logic [NCH*2-1:0]  I_ch_arburst;
  logic [NCH-1:0]    O_ch_arready;
  logic [NCH*DW-1:0] O_ch_rdata;
  logic [NCH-1:0]    O_ch_rvalid;
  logic [NCH-1:0]    O_ch_rlast;
  logic [NCH-1:0]    I_ch_rready;
  logic [GW-1:0]     O_grant;
  logic              O_busy;
  logic              I_err_clr;
  logic              O_burst_err;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_axi_rdata(I_axi_rdata), .I_axi_rvalid(I_axi_rvalid), .I_axi_rlast(I_axi_rlast),
    .O_axi_rready(O_axi_rready), .O_axi_araddr(O_axi_araddr), .I_axi_arready(I_axi_arready),
    .O_axi_arvalid(O_axi_arvalid), .O_axi_arlen(O_axi_arlen), .O_axi_arsize(O_axi_arsize),
    .O_axi_arburst(O_axi_arburst), .I_ch_araddr(I_ch_araddr), .I_ch_arvalid(I_ch_arvalid),
    .I_ch_arlen(I_ch_arlen), .I_ch_arsize(I_ch_arsize), .I_ch_arburst(I_ch_arburst),
    .O_ch_arready(O_ch_arready), .O_ch_rdata(O_ch_rdata), .O_ch_rvalid(O_ch_rvalid),
    .O_ch_rlast(O_ch_rlast), .I_ch_rready(I_ch_rready), .O_grant(O_grant), .O_busy(O_busy),
    .I_err_clr(I_err_clr), .O_burst_err(O_burst_err)
  );

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison, and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oneHot(input int g);
    return 4'(1 << g);
  endfunction

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Run one transaction. Raise reqMask, expect expGrant to win, forward the
  // AR beat, then deliver R beats 0..lastBeat with RLAST on lastBeat.
  // With toggleReady set, the master's rready alternates 0,1,0,1,...
  task automatic applyStimulus(input logic [3:0] reqMask, input int expGrant,
                               input logic [7:0] arlen, input int lastBeat,
                               input bit toggleReady, input logic expErr);
    int b;
    int cyc;
    logic rr;
    logic [63:0] beatData;
    logic [255:0] expData;
    I_ch_arvalid  = reqMask;
    I_ch_arlen    = {4{arlen}};
    I_axi_arready = 1'b1;
    #1;
    checkOutput("idle_arvalid", 256'(O_axi_arvalid), 256'(1'b0));
    tick();
    checkOutput("grant", 256'(O_grant), 256'(expGrant));
    checkOutput("ar_valid", 256'(O_axi_arvalid), 256'(1'b1));
    checkOutput("ar_addr", 256'(O_axi_araddr), 256'(32'h8000_0000 + 32'(expGrant * 256)));
    checkOutput("ar_len", 256'(O_axi_arlen), 256'(arlen));
    checkOutput("ar_size_burst", 256'({O_axi_arsize, O_axi_arburst}), 256'({3'(expGrant), 2'b01}));
    checkOutput("ch_arready", 256'(O_ch_arready), 256'(oneHot(expGrant)));
    tick();
    I_ch_arvalid = reqMask & ~oneHot(expGrant);
    b = 0;
    cyc = 0;
    while (b <= lastBeat && cyc < 64) begin
      rr = toggleReady ? ((cyc % 2) == 1) : 1'b1;
      beatData = {8'(expGrant), 8'(b), 16'h0, 32'hDEAD_BEEF};
      I_axi_rvalid = 1'b1;
      I_axi_rdata  = beatData;
      I_axi_rlast  = (b == lastBeat);
      I_ch_rready  = rr ? 4'hF : 4'h0;
      #1;
      expData = '0;
      expData[expGrant*64 +: 64] = beatData;
      checkOutput("r_ready", 256'(O_axi_rready), 256'(rr));
      checkOutput("ch_rdata", O_ch_rdata, expData);
      checkOutput("ch_rvalid", 256'(O_ch_rvalid), 256'(oneHot(expGrant)));
      checkOutput("ch_rlast", 256'(O_ch_rlast), 256'((b == lastBeat) ? oneHot(expGrant) : 4'h0));
      checkOutput("ch_arready_rd", 256'(O_ch_arready), 256'(4'h0));
      checkOutput("busy_rd", 256'(O_busy), 256'(1'b1));
      tick();
      cyc++;
      if (rr) b++;
    end
    I_axi_rvalid = 1'b0;
    I_axi_rlast  = 1'b0;
    I_ch_rready  = 4'h0;
    I_ch_arvalid = 4'h0;
    checkOutput("busy_after", 256'(O_busy), 256'(1'b0));
    checkOutput("burst_err", 256'(O_burst_err), 256'(expErr));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    I_axi_rdata = '0; I_axi_rvalid = 1'b0; I_axi_rlast = 1'b0; I_axi_arready = 1'b0;
    I_ch_arvalid = '0; I_ch_arlen = '0; I_ch_rready = '0; I_err_clr = 1'b0;
    I_ch_arsize  = {3'd3, 3'd2, 3'd1, 3'd0};
    I_ch_arburst = {4{2'b01}};
    for (int k = 0; k < NCH; k++) I_ch_araddr[k*AW +: AW] = 32'h8000_0000 + 32'(k * 256);
    tick();
    tick();
    checkOutput("rst_busy", 256'(O_busy), 256'(1'b0));
    checkOutput("rst_grant", 256'(O_grant), 256'(2'd0));
    checkOutput("rst_outs", 256'({O_axi_arvalid, O_axi_rready, O_ch_arready, O_ch_rvalid, O_burst_err}), 256'(0));
    rst = 1'b0;

    // Single request from ch0, single beat
    applyStimulus(4'b0001, 0, 8'd0, 0, 1'b0, 1'b0);

    // ch0 and ch1 contend, expected order 0,1,0,1
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b0011, i % 2, 8'd0, 0, 1'b0, 1'b0);

    // All four contend, two beats each, expected order 0,1,2,3,0
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, i % 4, 8'd1, 1, 1'b0, 1'b0);

    // rr_ptr=1 with only ch0 requesting; rready toggles during a 4-beat burst
    applyStimulus(4'b0001, 0, 8'd3, 3, 1'b1, 1'b0);

    // Early RLAST on beat 2 of 4, then clear
    applyStimulus(4'b0010, 1, 8'd3, 2, 1'b0, 1'b1);
    I_err_clr = 1'b1;
    tick();
    I_err_clr = 1'b0;
    checkOutput("err_clr_early", 256'(O_burst_err), 256'(1'b0));

    // Extra beat beyond arlen=0, then clear
    applyStimulus(4'b0100, 2, 8'd0, 1, 1'b0, 1'b1);
    I_err_clr = 1'b1;
    tick();
    I_err_clr = 1'b0;
    checkOutput("err_clr_extra", 256'(O_burst_err), 256'(1'b0));

    // ch3 withdraws its request during AR; rr_ptr must stay at 3
    I_ch_arvalid  = 4'b1000;
    I_axi_arready = 1'b0;
    tick();
    checkOutput("abort_grant", 256'(O_grant), 256'(2'd3));
    I_ch_arvalid = 4'b0000;
    #1;
    checkOutput("abort_arvalid", 256'(O_axi_arvalid), 256'(1'b0));
    tick();
    checkOutput("abort_idle", 256'({O_busy, O_burst_err}), 256'(2'b00));
    applyStimulus(4'b1001, 3, 8'd0, 0, 1'b0, 1'b0);

    // Reset during beat 1 of a 4-beat ch2 burst
    doReset();
    I_ch_arvalid  = 4'b0100;
    I_ch_arlen    = {4{8'd3}};
    I_axi_arready = 1'b1;
    tick();
    tick();
    I_ch_arvalid = 4'b0000;
    I_axi_rvalid = 1'b1; I_axi_rlast = 1'b0; I_ch_rready = 4'hF;
    I_axi_rdata  = 64'h1111;
    tick();
    I_axi_rdata = 64'h2222;
    #2;
    checkOutput("pre_rst_busy", 256'(O_busy), 256'(1'b1));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 256'(O_busy), 256'(1'b0));
    checkOutput("mid_rst_grant", 256'(O_grant), 256'(2'd0));
    checkOutput("mid_rst_outs", 256'({O_ch_rvalid, O_ch_arready, O_axi_rready}), 256'(0));
    I_axi_rvalid = 1'b0; I_ch_rready = 4'h0;
    tick();
    rst = 1'b0;
    tick();
    // rr_ptr back at 0: ch1 beats ch3
    applyStimulus(4'b1010, 1, 8'd0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_rr.md
Name: axi_rd_arbiter_rr

Overview:
- Parametrised N-channel AXI4 read-path arbiter. Sits between the pipeline's read masters (IFU, LSU, DMA/cache refill) and the single AXI read port to memory.
- Grants one channel at a time with round-robin fairness across NCH channels. Routes that channel's AR beat upstream and its R burst back.
- Tracks burst length per transaction and flags RLAST protocol violations.

Parameters:
- NCH, 2, number of read channels (2..8); GW = $clog2(NCH) is a derived localparam, not a parameter.
- AW, 32, address width.
- DW, 64, data width.

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst  in  1  reset, asynchronous, active-high.
- I_axi_rdata  in  DW  upstream read data.
- I_axi_rvalid  in  1  upstream R valid.
- I_axi_rlast  in  1  upstream R last.
- O_axi_rready  out  1  R ready to upstream.
- O_axi_araddr  out  AW  AR address.
- I_axi_arready  in  1  AR ready from upstream.
- O_axi_arvalid  out  1  AR valid.
- O_axi_arlen  out  8  AR burst length.
- O_axi_arsize  out  3  AR size.
- O_axi_arburst  out  2  AR burst type.
- I_ch_araddr  in  NCH*AW  per-channel address; channel k occupies [k*AW +: AW].
- I_ch_arvalid  in  NCH  per-channel AR valid.
- I_ch_arlen  in  NCH*8  per-channel burst length.
- I_ch_arsize  in  NCH*3  per-channel size.
- I_ch_arburst  in  NCH*2  per-channel burst type.
- O_ch_arready  out  NCH  per-channel AR ready.
- O_ch_rdata  out  NCH*DW  per-channel R data.
- O_ch_rvalid  out  NCH  per-channel R valid.
- O_ch_rlast  out  NCH  per-channel R last.
- I_ch_rready  in  NCH  per-channel R ready.
- O_grant  out  GW  currently granted channel index.
- O_busy  out  1  high while state is not IDLE.
- I_err_clr  in  1  clears O_burst_err.
- O_burst_err  out  1  sticky RLAST/length mismatch flag.

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, O_grant=0, beat_cnt=0, O_burst_err=0. All valid, ready and last outputs are 0; all data and address outputs are 0.
- State machine: IDLE -> AR -> RD -> IDLE.
- IDLE:
  - If any I_ch_arvalid is set, grant the first requesting index scanning rr_ptr, rr_ptr+1, ... mod NCH.
  - Register the grant into O_grant and go to AR. Grant latency is exactly 1 cycle: arvalid at cycle t gives O_axi_arvalid at t+1.
  - No AR or R routing occurs in IDLE.
- AR:
  - Upstream AR signals = the granted channel's fields. O_axi_arvalid = I_ch_arvalid[g]. O_ch_arready[g] = I_axi_arready. All other arready = 0.
  - On handshake (O_axi_arvalid & I_axi_arready): beat_cnt <= arlen, rr_ptr <= (g+1) mod NCH, go to RD.
  - If I_ch_arvalid[g] drops before handshake (master protocol violation), return to IDLE. rr_ptr is unchanged and the flag is not set.
- RD:
  - O_axi_rready = I_ch_rready[g].
  - O_ch_rdata[g], O_ch_rvalid[g] and O_ch_rlast[g] mirror upstream. All other channels' R outputs = 0. No AR is forwarded.
  - On each R handshake with rlast=0: beat_cnt decrements.
  - On R handshake with rlast=1: go to IDLE. If beat_cnt != 0, set O_burst_err.
  - On R handshake with rlast=0 and beat_cnt == 0: set O_burst_err, stay in RD, and keep beat_cnt at 0 (saturate, no wrap).
- Fairness: after serving channel k, channel k has the lowest priority. With all NCH requesting, grants cycle 0,1,..,NCH-1,0.
- A request arriving in the same cycle as an RLAST handshake is seen in the next IDLE cycle. There is no back-to-back bypass, so there is at least one IDLE cycle between transactions.
- Only one outstanding transaction at a time.
- O_burst_err: set wins over I_err_clr when both occur in the same cycle. Otherwise I_err_clr clears it on the next edge.
- Reset asserted mid-burst: the block returns to IDLE immediately and outputs go to 0. The upstream slave must be reset together with this block.
- NCH=1: GW is forced to 1 and the grant is always 0.

Test Plan:
- Single request: ch0 requests araddr=0x8000_0000, arlen=0, with I_axi_arready=1. Required: O_axi_arvalid rises 1 cycle after ch0 arvalid; 1 beat 0xDEAD_BEEF with rlast is delivered to ch0 only; O_busy falls the cycle after the last beat.
- Simultaneous requests, NCH=2: ch0 and ch1 request together, 4 times. Required: grant order 0,1,0,1; the loser's arready stays 0 throughout the winner's transaction.
- Round-robin, NCH=4: all channels request continuously with arlen=1. Required: grants 0,1,2,3,0; each channel receives exactly 2 beats and only its own rvalid toggles.
- Backpressure: arlen=3 and I_ch_rready toggles every cycle. Required: O_axi_rready follows it; 4 beats are delivered in order; the state leaves RD only on the rlast handshake; O_burst_err=0.
- Length mismatch: arlen=3 with rlast on beat 2 gives O_burst_err=1 and a return to IDLE. Extra beats beyond arlen also set O_burst_err. A later I_err_clr pulse clears it.
- Reset mid-burst: I_rst is asserted during beat 1 of 4. Required: O_busy=0, all rvalid/arready=0 and O_grant=0 asynchronously; after release, a ch1 request is granted first because rr_ptr=0 and ch0 is idle.
